// File: rtl/ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_config
//   Power-up register loader for the OV7670. Walks an external synchronous ROM
//   of {reg_addr, reg_data} words from address 0 and issues one SCCB 3-phase
//   write (ID, sub-address, data) per entry. 16'hF0F0 inserts a fixed wait,
//   16'hFFFF terminates the table. done gates use of the capture path.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-low reset
//   start     in   1-clk pulse, accepted only while idle or done
//   rom_addr  out  ROM address (ROM_AW bits)
//   rom_data  in   {reg_addr, reg_data}, valid one clk after rom_addr
//   sioc      out  SCCB clock, push-pull
//   siod_oe   out  1 = pull SIOD low, 0 = release (pull-up gives 1)
//   busy      out  high from accepted start until done
//   done      out  high after the end entry, cleared by the next start
// ---------------------------------------------------------------------------
module ov7670_sccb_config #(
    parameter int          CLK_DIV   = 250,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int          ROM_AW    = 8,
    parameter int          DELAY_CYC = 1000000,
    parameter int          GAP_Q     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sioc,
    output logic              siod_oe,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DLY_W = $clog2(DELAY_CYC + 1);
    localparam int GAP_W = (GAP_Q > 1) ? $clog2(GAP_Q) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_Q - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [4:0]        bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              fetch_q, fetch_d;
    logic [26:0]       frame_q, frame_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              sioc_q, sioc_d;
    logic              oe_q, oe_d;
    logic              tick;
    logic              last_entry;
    logic [4:0]        bit_idx;

    assign tick       = (div_q == DIV_LAST);
    assign last_entry = (addr_q == {ROM_AW{1'b1}});

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        dly_d   = dly_q;
        fetch_d = fetch_q;
        frame_d = frame_q;
        addr_d  = addr_q;

        // Quarter divider runs only while the bus is being timed.
        if (state_q == S_START || state_q == S_BIT || state_q == S_STOP || state_q == S_GAP) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    fetch_d = 1'b0;
                    div_d   = '0;
                end
            end
            S_FETCH: begin
                // First cycle lets the ROM register the new address.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else if (rom_data == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (rom_data == 16'hF0F0) begin
                    state_d = S_DELAY;
                    dly_d   = '0;
                end else begin
                    state_d = S_START;
                    qtr_d   = '0;
                    div_d   = '0;
                    // The 1 after each byte releases SIOD for the don't-care bit.
                    frame_d = {DEV_ID, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                end
            end
            S_START: begin
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        state_d = S_BIT;
                        qtr_d   = '0;
                        bit_d   = '0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 5'd26) begin
                            state_d = S_STOP;
                            qtr_d   = '0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        if (last_entry) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            addr_d  = addr_q + 1'b1;
                            fetch_d = 1'b0;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    if (last_entry) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + 1'b1;
                        fetch_d = 1'b0;
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line levels are decoded from the next state so they leave registers
    // and change on the same edge as the state/quarter they belong to.
    always_comb begin
        sioc_d  = 1'b1;
        oe_d    = 1'b0;
        bit_idx = 5'd26 - bit_d;
        case (state_d)
            S_START: begin
                oe_d   = 1'b1;
                sioc_d = (qtr_d == 2'd0);
            end
            S_BIT: begin
                oe_d   = ~frame_d[bit_idx];
                sioc_d = qtr_d[1];
            end
            S_STOP: begin
                sioc_d = (qtr_d != 2'd0);
                oe_d   = (qtr_d != 2'd2);
            end
            default: begin
                sioc_d = 1'b1;
                oe_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            dly_q   <= '0;
            fetch_q <= 1'b0;
            frame_q <= '0;
            addr_q  <= '0;
            sioc_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            dly_q   <= dly_d;
            fetch_q <= fetch_d;
            frame_q <= frame_d;
            addr_q  <= addr_d;
            sioc_q  <= sioc_d;
            oe_q    <= oe_d;
        end
    end

    assign rom_addr = addr_q;
    assign sioc     = sioc_q;
    assign siod_oe  = oe_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_config
//   Drives ov7670_sccb_config with small directed and random ROM tables.
//   A bus monitor decodes start/stop conditions and SIOD at SIOC rising
//   edges; a table walker predicts the writes, final address and timing.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_config;

    localparam int CLK_DIV   = 4;
    localparam int ROM_AW    = 3;
    localparam int DEPTH     = 1 << ROM_AW;
    localparam int DELAY_CYC = 50;
    localparam int GAP_Q     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data = 16'h0000;
    logic              sioc, siod_oe, busy, done;

    logic [15:0] rom_mem [0:DEPTH-1];

    int tests_run = 0;
    int tests_failed = 0;

    ov7670_sccb_config #(
        .CLK_DIV(CLK_DIV), .DEV_ID(8'h42), .ROM_AW(ROM_AW),
        .DELAY_CYC(DELAY_CYC), .GAP_Q(GAP_Q)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .sioc(sioc), .siod_oe(siod_oe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous ROM, one clock of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic        sioc_p = 1'b1, siod_p = 1'b1, siod_now;
    logic [31:0] sh;
    int          nb = 0;
    bit          in_fr = 0;
    int          cyc = 0;
    int          toggles = 0;
    bit          act_seen = 0;
    int          first_act_cyc = 0;
    logic [26:0] got_q [$];
    int          len_q [$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            siod_now = ~siod_oe;
            if (!rst) begin
                in_fr = 0;
            end else begin
                if (sioc !== sioc_p || siod_now !== siod_p) begin
                    toggles++;
                    if (!act_seen) begin
                        act_seen = 1;
                        first_act_cyc = cyc;
                    end
                end
                if (sioc && sioc_p && siod_p && !siod_now) begin
                    in_fr = 1;
                    nb = 0;
                    sh = '0;
                end else if (sioc && sioc_p && !siod_p && siod_now && in_fr) begin
                    // The last SIOC rise belongs to the stop condition itself.
                    got_q.push_back(sh[27:1]);
                    len_q.push_back(nb - 1);
                    in_fr = 0;
                end else if (!sioc_p && sioc && in_fr) begin
                    sh = {sh[30:0], siod_now};
                    nb++;
                end
            end
            sioc_p = sioc;
            siod_p = siod_now;
        end
    end

    // ---------------- reference: walk the table ----------------
    logic [26:0] exp_q [$];
    int          exp_fin;

    task automatic build_expect();
        logic [15:0] w;
        exp_q.delete();
        exp_fin = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            w = rom_mem[a];
            if (w == 16'hFFFF) begin
                exp_fin = a;
                break;
            end
            if (w != 16'hF0F0)
                exp_q.push_back({8'h42, 1'b1, w[15:8], 1'b1, w[7:0], 1'b1});
        end
    endtask

    task automatic fill_rom(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int a = 0; a < DEPTH; a++) rom_mem[a] = 16'hFFFF;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
    endtask

    task automatic run_case(input string name, input int mid_start_at);
        int n;
        int start_cyc;
        int nf;
        build_expect();
        got_q.delete();
        len_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        toggles = 0;
        act_seen = 0;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({name, ".busy_on"}, busy, 1);
        check_val({name, ".done_clr"}, done, 0);
        n = 0;
        while (!done && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == mid_start_at);
        end
        start = 1'b0;
        check_val({name, ".finished"}, done, 1);
        check_val({name, ".busy_off"}, busy, 0);
        check_val({name, ".rom_addr"}, rom_addr, exp_fin);
        check_val({name, ".n_writes"}, got_q.size(), exp_q.size());
        nf = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nf; i++) begin
            $display("[TB] %s write %0d: id=%02h reg=%02h val=%02h bits=%0d", name, i,
                     got_q[i][26:19], got_q[i][17:10], got_q[i][8:1], len_q[i]);
            check_val($sformatf("%s.w%0d.nbits", name, i), len_q[i], 27);
            check_val($sformatf("%s.w%0d.frame", name, i), got_q[i], exp_q[i]);
        end
        if (rom_mem[0] == 16'hF0F0)
            check_val({name, ".delay_idle"}, (first_act_cyc - start_cyc) >= DELAY_CYC, 1);
        if (rom_mem[0] == 16'hFFFF) begin
            check_val({name, ".empty_fast"}, n <= 3, 1);
            check_val({name, ".empty_quiet"}, toggles, 0);
        end
    endtask

    initial begin
        int n;
        for (int a = 0; a < DEPTH; a++) rom_mem[a] = 16'hFFFF;

        // 1. Reset values and a quiet bus with no start.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.sioc", sioc, 1);
        check_val("rst.oe", siod_oe, 0);
        check_val("rst.busy", busy, 0);
        check_val("rst.done", done, 0);
        check_val("rst.addr", rom_addr, 0);
        rst = 1'b1;
        toggles = 0;
        repeat (1000) @(posedge clk);
        #1;
        check_val("idle.toggles", toggles, 0);
        check_val("idle.busy", busy, 0);

        // 2. Single write.
        fill_rom(16'h1280, 16'hFFFF, 16'hFFFF);
        run_case("single", -1);

        // 3. Delay entry then write.
        fill_rom(16'hF0F0, 16'h1100, 16'hFFFF);
        run_case("delay", -1);

        // 4. Empty table.
        fill_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_case("empty", -1);

        // 5. Start pulsed mid-transaction is ignored.
        fill_rom(16'h1280, 16'hFFFF, 16'hFFFF);
        run_case("midstart", 200);

        // 6. Reset during byte 2, then a clean restart from address 0.
        fill_rom(16'h1280, 16'h3456, 16'hFFFF);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(in_fr && nb >= 12) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("abort.reached_byte2", (in_fr && nb >= 12), 1);
        rst = 1'b0;
        #1;
        check_val("abort.sioc", sioc, 1);
        check_val("abort.oe", siod_oe, 0);
        check_val("abort.busy", busy, 0);
        check_val("abort.addr", rom_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        run_case("restart", -1);

        // 7. Random tables, including one with no terminator (ROM end).
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int k;
                k = $urandom_range(0, 9);
                if (r == 0 || k > 1) begin
                    rom_mem[a] = 16'($urandom);
                    if (rom_mem[a] == 16'hFFFF || rom_mem[a] == 16'hF0F0) rom_mem[a] = 16'h1234;
                end else if (k == 0) begin
                    rom_mem[a] = 16'hF0F0;
                end else begin
                    rom_mem[a] = 16'hFFFF;
                end
            end
            run_case($sformatf("rand%0d", r), (r == 3) ? 150 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
